// File: rtl/pending_event_arbiter.sv
// pending_event_arbiter
// Collects single-cycle event pulses into a sticky pending bitmap and issues
// the highest-index pending event through a registered valid/ready slot.
// A pulse on a source that is already pending (and not being issued on the
// same edge) is lost and counted in a saturating drop counter.
module pending_event_arbiter #(
    parameter int WIDTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         set_i,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [$clog2(WIDTH)-1:0] out_idx,
    output logic [WIDTH-1:0]         pending_o,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SUM_W = DROP_W + CNT_W;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [WIDTH-1:0]  pending_q, pending_d;
    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;
    logic              load;
    logic [WIDTH-1:0]  clr;
    logic [WIDTH-1:0]  drop_vec;
    logic [CNT_W-1:0]  drop_n;
    logic [SUM_W-1:0]  drop_sum;

    // Highest pending index wins: the ascending scan lets later hits override.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        sel_any = |pending_q;
    end

    // Load a new event whenever the slot is empty or being accepted this edge.
    always_comb begin
        load = sel_any && (!out_valid_q || out_ready);
        clr  = '0;
        if (load) begin
            clr[sel_idx] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear, so a set on the bit being issued re-pends it.
    always_comb begin
        pending_d = (pending_q & ~clr) | set_i;
    end

    // Count lost pulses this edge and add them with saturation.
    always_comb begin
        drop_vec = set_i & pending_q & ~clr;
        drop_n   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            drop_n = drop_n + CNT_W'(drop_vec[i]);
        end
        drop_sum = SUM_W'(drop_q) + SUM_W'(drop_n);
        if (drop_sum > SUM_W'(DROP_MAX)) begin
            drop_d = DROP_MAX;
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end
    end

    // Output slot: load beats drain; a stalled slot holds its index.
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = sel_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // All state registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            drop_q      <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign pending_o  = pending_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pending_event_arbiter.sv
// Bench for pending_event_arbiter: two instances (8-bit and 2-bit drop
// counters) share stimulus; a behavioural model is compared every cycle and
// directed literal expectations pin the model.
module tb_pending_event_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] set_i = 8'hFF;
    logic       out_ready = 1'b0;

    logic       out_valid, out_valid2;
    logic [2:0] out_idx, out_idx2;
    logic [7:0] pending_o, pending_o2;
    logic [7:0] drop_count;
    logic [1:0] drop_count2;

    int total = 0;
    int bad = 0;

    pending_event_arbiter #(.WIDTH(8), .DROP_W(8)) dut (
        .clk(clk), .reset(reset), .set_i(set_i), .out_ready(out_ready),
        .out_valid(out_valid), .out_idx(out_idx), .pending_o(pending_o),
        .drop_count(drop_count)
    );

    pending_event_arbiter #(.WIDTH(8), .DROP_W(2)) dut2 (
        .clk(clk), .reset(reset), .set_i(set_i), .out_ready(out_ready),
        .out_valid(out_valid2), .out_idx(out_idx2), .pending_o(pending_o2),
        .drop_count(drop_count2)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [7:0] m_pend = 8'h00;
    logic       m_valid = 1'b0;
    int         m_idx = 0;
    int         m_drop8 = 0;
    int         m_drop2 = 0;

    always @(posedge clk or posedge reset) begin
        int top;
        int lost;
        bit take;
        logic [7:0] np;
        if (reset) begin
            m_pend  <= 8'h00;
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_drop8 <= 0;
            m_drop2 <= 0;
        end else begin
            top = -1;
            for (int i = 0; i < 8; i++) if (m_pend[i]) top = i;
            take = (top >= 0) && (!m_valid || out_ready);
            np = m_pend;
            lost = 0;
            if (take) np[top] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (set_i[i]) begin
                    if (m_pend[i] && !(take && i == top)) lost++;
                    np[i] = 1'b1;
                end
            end
            m_pend <= np;
            if (take) begin
                m_valid <= 1'b1;
                m_idx   <= top;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            m_drop8 <= (m_drop8 + lost > 255) ? 255 : m_drop8 + lost;
            m_drop2 <= (m_drop2 + lost > 3) ? 3 : m_drop2 + lost;
        end
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        check("m_valid", 32'(out_valid), 32'(m_valid));
        check("m_idx", 32'(out_idx), 32'(m_idx));
        check("m_pend", 32'(pending_o), 32'(m_pend));
        check("m_drop8", 32'(drop_count), 32'(m_drop8));
        check("m_valid2", 32'(out_valid2), 32'(m_valid));
        check("m_idx2", 32'(out_idx2), 32'(m_idx));
        check("m_pend2", 32'(pending_o2), 32'(m_pend));
        check("m_drop2", 32'(drop_count2), 32'(m_drop2));
    end

    task automatic drive(input logic [7:0] s, input logic r);
        set_i = s;
        out_ready = r;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk_slot(string name, logic v, logic [2:0] idx, logic [7:0] pend);
        check({name, "_valid"}, 32'(out_valid), 32'(v));
        if (v) check({name, "_idx"}, 32'(out_idx), 32'(idx));
        check({name, "_pend"}, 32'(pending_o), 32'(pend));
    endtask

    initial begin
        // Reset held with all sets high
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk_slot("rst", 1'b0, 3'd0, 8'h00);
            check("rst_idx", 32'(out_idx), 0);
            check("rst_drop", 32'(drop_count), 0);
        end
        reset = 1'b0;
        drive(8'h00, 1'b1);
        nxt();

        // Single event
        drive(8'h10, 1'b1);
        nxt();
        chk_slot("single_e1", 1'b0, 3'd0, 8'h10);
        drive(8'h00, 1'b1);
        nxt();
        chk_slot("single_e2", 1'b1, 3'd4, 8'h00);
        nxt();
        chk_slot("single_e3", 1'b0, 3'd0, 8'h00);

        // Priority and stall
        drive(8'h05, 1'b0);
        nxt();
        drive(8'h00, 1'b0);
        nxt();
        chk_slot("prio", 1'b1, 3'd2, 8'h01);
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk_slot("stall", 1'b1, 3'd2, 8'h01);
        end
        drive(8'h00, 1'b1);
        nxt();
        chk_slot("prio_next", 1'b1, 3'd0, 8'h00);
        nxt();
        chk_slot("prio_empty", 1'b0, 3'd0, 8'h00);

        // Burst drain
        drive(8'hFF, 1'b1);
        nxt();
        drive(8'h00, 1'b1);
        for (int k = 7; k >= 0; k--) begin
            nxt();
            check("burst_valid", 32'(out_valid), 1);
            check("burst_idx", 32'(out_idx), 32'(k));
        end
        nxt();
        check("burst_end", 32'(out_valid), 0);
        check("burst_drop", 32'(drop_count), 0);

        // Drop and set-wins
        drive(8'h01, 1'b0);
        nxt();
        drive(8'h00, 1'b0);
        nxt();
        chk_slot("fill", 1'b1, 3'd0, 8'h00);
        drive(8'h08, 1'b0);
        nxt();
        nxt();
        drive(8'h00, 1'b0);
        check("drop1", 32'(drop_count), 1);
        check("drop1_pend", 32'(pending_o), 32'h08);
        nxt();
        drive(8'h08, 1'b1);
        nxt();
        chk_slot("setwins", 1'b1, 3'd3, 8'h08);
        check("setwins_drop", 32'(drop_count), 1);
        drive(8'h00, 1'b1);
        nxt();
        chk_slot("setwins_reissue", 1'b1, 3'd3, 8'h00);
        nxt();
        chk_slot("setwins_empty", 1'b0, 3'd0, 8'h00);

        // Saturation: 5 more drops on top of 1
        drive(8'h03, 1'b0);
        nxt();
        drive(8'h01, 1'b0);
        for (int i = 0; i < 5; i++) nxt();
        drive(8'h00, 1'b0);
        nxt();
        check("sat_drop8", 32'(drop_count), 6);
        check("sat_drop2", 32'(drop_count2), 3);
        chk_slot("sat_slot", 1'b1, 3'd1, 8'h01);

        // Reset mid-operation, asserted between edges
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        drive(8'h01, 1'b0);
        nxt();
        drive(8'hA0, 1'b0);
        nxt();
        drive(8'h00, 1'b0);
        chk_slot("pre_rst", 1'b1, 3'd0, 8'hA0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", 32'(out_valid), 0);
        check("async_idx", 32'(out_idx), 0);
        check("async_pend", 32'(pending_o), 0);
        check("async_drop", 32'(drop_count), 0);
        check("async_drop2", 32'(drop_count2), 0);
        nxt();
        reset = 1'b0;
        drive(8'h02, 1'b1);
        nxt();
        drive(8'h00, 1'b1);
        nxt();
        chk_slot("post_rst", 1'b1, 3'd1, 8'h00);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
